// File: rtl/invertn_pipe.sv
// Elastic DEPTH-stage pipeline that passes, inverts, XORs or XNORs each accepted word with MASK.
// Define INVERTN_PIPE_CNT_EN to add the 16-bit COUNT output (output transfers since reset).
module invertn_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] I,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] MASK,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] O
`ifdef INVERTN_PIPE_CNT_EN
    ,
    output logic [15:0]      COUNT
`endif
);

    typedef enum logic [1:0] {
        OP_PASS   = 2'b00,
        OP_INVERT = 2'b01,
        OP_XOR    = 2'b10,
        OP_XNOR   = 2'b11
    } op_e;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] advance;
    logic [WIDTH-1:0] data_vec [DEPTH];
    logic [WIDTH-1:0] result;

    // The operation is resolved on entry, so later MODE/MASK changes cannot reach accepted words.
    always_comb begin
        result = I;
        case (op_e'(MODE))
            OP_PASS:   result = I;
            OP_INVERT: result = ~I;
            OP_XOR:    result = I ^ MASK;
            OP_XNOR:   result = ~(I ^ MASK);
            default:   result = I;
        endcase
    end

    // Ready ripples back from the output; an empty stage always accepts, so there are no bubbles.
    assign advance[DEPTH-1] = ~valid_vec[DEPTH-1] | O_READY;

    generate
        for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_advance
            assign advance[gi] = ~valid_vec[gi] | advance[gi+1];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             stage_valid_reg;
            logic [WIDTH-1:0] stage_data_reg;
            logic             in_valid;
            logic [WIDTH-1:0] in_data;

            if (gi == 0) begin : g_head
                assign in_valid = I_VALID;
                assign in_data  = result;
            end else begin : g_body
                assign in_valid = valid_vec[gi-1];
                assign in_data  = data_vec[gi-1];
            end

            always_ff @(posedge CLK) begin
                if (!RESETN) begin
                    stage_valid_reg <= 1'b0;
                    stage_data_reg  <= '0;
                end else if (advance[gi]) begin
                    stage_valid_reg <= in_valid;
                    if (in_valid) begin
                        stage_data_reg <= in_data;
                    end
                end
            end

            assign valid_vec[gi] = stage_valid_reg;
            assign data_vec[gi]  = stage_data_reg;
        end
    endgenerate

    assign I_READY = advance[0];
    assign O_VALID = valid_vec[DEPTH-1];
    assign O       = data_vec[DEPTH-1];

`ifdef INVERTN_PIPE_CNT_EN
    logic [15:0] count_reg;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            count_reg <= 16'h0000;
        end else if (O_VALID && O_READY) begin
            count_reg <= count_reg + 16'h0001;
        end
    end

    assign COUNT = count_reg;
`endif

endmodule
